freq_meter_bcd: RTL and testbench

Parametrised reciprocal-free frequency meter. It counts rising edges of an asynchronous input over a programmable gate window and latches the result as a packed BCD value with an overflow flag. It also drives a multiplexed, active-low 7-segment display with leading-zero blanking. It sits between the board input pin and the display pins, and exposes the latched BCD value to other modules.

---
 rtl/freq_meter_pkg.sv | 66 ++++++
 rtl/seg7_scan.sv | 82 ++++++++
 rtl/freq_meter_bcd.sv | 112 +++++++++++
 tb/tb_freq_meter_bcd.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared types, 7-segment glyphs and BCD helpers
// for the frequency meter.
package freq_meter_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam int MAX_DIGITS = 8;

    // Active-low segments ordered {a,b,c,d,e,f,g}
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    function automatic logic [6:0] seg_glyph(
        input bcd_digit_t d
    );
        logic [6:0] g;
        case (d)
            4'd0:    g = SEG_0;
            4'd1:    g = SEG_1;
            4'd2:    g = SEG_2;
            4'd3:    g = SEG_3;
            4'd4:    g = SEG_4;
            4'd5:    g = SEG_5;
            4'd6:    g = SEG_6;
            4'd7:    g = SEG_7;
            4'd8:    g = SEG_8;
            4'd9:    g = SEG_9;
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

    // Returns {carry_out, v + 1} over the low n digits;
    // carry_out is set when the n digits were all 9s.
    function automatic logic [32:0] bcd_inc(
        input logic [31:0] v,
        input int          n
    );
        logic [31:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < n && c) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return {c, r};
    endfunction

endpackage

// File: rtl/seg7_scan.sv
// Multiplexed active-low 7-segment scanner with
// leading-zero blanking and overflow dashes.
module seg7_scan
    import freq_meter_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int REFRESH_CYCLES = 100_000
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic [4*DIGITS-1:0] bcd,
    input  logic                overflow,
    output logic [DIGITS-1:0]   anode,
    output logic [6:0]          cathode
);

    localparam int RW = (REFRESH_CYCLES > 1) ?
                        $clog2(REFRESH_CYCLES) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [RW-1:0]     refresh;
    logic [IW-1:0]     idx;
    logic              refresh_wrap;
    bcd_digit_t        digit;
    logic              upper_zero;
    logic [6:0]        glyph;
    logic [DIGITS-1:0] anode_nxt;

    assign refresh_wrap = (refresh == RW'(REFRESH_CYCLES - 1));

    // Refresh timer; each wrap moves the scan to the next digit
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            refresh <= '0;
            idx     <= '0;
        end else if (refresh_wrap) begin
            refresh <= '0;
            if (idx == IW'(DIGITS - 1)) begin
                idx <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end else begin
            refresh <= refresh + 1'b1;
        end
    end

    // Select the scanned digit and decide dash / blank / glyph
    always_comb begin
        digit      = '0;
        upper_zero = 1'b1;
        anode_nxt  = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (IW'(i) == idx) begin
                digit        = bcd[4*i +: 4];
                anode_nxt[i] = 1'b0;
            end
            if (IW'(i) >= idx && bcd[4*i +: 4] != 4'd0) begin
                upper_zero = 1'b0;
            end
        end
        if (overflow) begin
            glyph = SEG_DASH;
        end else if (idx != '0 && upper_zero) begin
            glyph = SEG_BLANK;
        end else begin
            glyph = seg_glyph(digit);
        end
    end

    // Register display pins so anode and cathode switch together
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            anode   <= '1;
            cathode <= SEG_BLANK;
        end else begin
            anode   <= anode_nxt;
            cathode <= glyph;
        end
    end

endmodule

// File: rtl/freq_meter_bcd.sv
// Gated edge counter producing a latched BCD frequency
// reading and driving a multiplexed 7-segment display.
module freq_meter_bcd
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES    = 100_000_000,
    parameter int DIGITS         = 4,
    parameter int REFRESH_CYCLES = 100_000
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                IN,
    output logic [4*DIGITS-1:0] freq_bcd,
    output logic                freq_valid,
    output logic                overflow,
    output logic [6:0]          cathode,
    output logic [DIGITS-1:0]   anode,
    output logic                DP
);

    localparam int W  = 4 * DIGITS;
    localparam int GW = $clog2(GATE_CYCLES);

    logic          sync1;
    logic          sync2;
    logic          sync3;
    logic          edge_p;
    logic [GW-1:0] gate;
    logic          gate_end;
    logic [W-1:0]  run;
    logic [W-1:0]  run_nxt;
    logic          run_ovf;
    logic          ovf_nxt;
    logic [31:0]   run_ext;
    logic [32:0]   inc_res;

    assign DP       = 1'b1;
    assign edge_p   = sync2 & ~sync3;
    assign gate_end = (gate == GW'(GATE_CYCLES - 1));

    // Two-flop synchroniser plus delayed copy for edge detection
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= IN;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    // Running count plus this cycle's edge, saturating at all 9s
    always_comb begin
        run_ext        = '0;
        run_ext[W-1:0] = run;
        inc_res        = bcd_inc(run_ext, DIGITS);
        run_nxt        = run;
        ovf_nxt        = run_ovf;
        if (edge_p) begin
            if (inc_res[32]) begin
                ovf_nxt = 1'b1;
            end else begin
                run_nxt = inc_res[W-1:0];
            end
        end
    end

    if (W < 32) begin : g_unused
        logic unused_inc;
        assign unused_inc = ^inc_res[31:W];
    end

    // Gate timer, running counter and end-of-window latch
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            gate       <= '0;
            run        <= '0;
            run_ovf    <= 1'b0;
            freq_bcd   <= '0;
            overflow   <= 1'b0;
            freq_valid <= 1'b0;
        end else begin
            freq_valid <= gate_end;
            if (gate_end) begin
                gate     <= '0;
                freq_bcd <= run_nxt;
                overflow <= ovf_nxt;
                run      <= '0;
                run_ovf  <= 1'b0;
            end else begin
                gate    <= gate + 1'b1;
                run     <= run_nxt;
                run_ovf <= ovf_nxt;
            end
        end
    end

    seg7_scan #(
        .DIGITS         (DIGITS),
        .REFRESH_CYCLES (REFRESH_CYCLES)
    ) u_scan (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .bcd      (freq_bcd),
        .overflow (overflow),
        .anode    (anode),
        .cathode  (cathode)
    );

endmodule

// File: tb/tb_freq_meter_bcd.sv
// Directed bench for freq_meter_bcd: a 4-digit
// instance plus a 2-digit instance driven into overflow.
module tb_freq_meter_bcd;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a_n;
    logic        rst_b_n;
    logic        man_in;
    logic        sq_in;
    logic        sq_en;
    logic        in_a;
    logic        in_b;
    logic [1:0]  b_ph;
    int          sq_ph;

    logic [15:0] a_bcd;
    logic        a_valid;
    logic        a_ovf;
    logic [6:0]  a_cat;
    logic [3:0]  a_an;
    logic        a_dp;

    logic [7:0]  b_bcd;
    logic        b_valid;
    logic        b_ovf;
    logic [6:0]  b_cat;
    logic [1:0]  b_an;
    logic        b_dp;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    localparam logic [6:0] G0   = 7'b0000001;
    localparam logic [6:0] G2   = 7'b0010010;
    localparam logic [6:0] G4   = 7'b1001100;
    localparam logic [6:0] BLK  = 7'b1111111;
    localparam logic [6:0] DASH = 7'b1111110;

    assign in_a = sq_en ? sq_in : man_in;

    freq_meter_bcd #(
        .GATE_CYCLES    (1000),
        .DIGITS         (4),
        .REFRESH_CYCLES (8)
    ) dut_a (
        .CLK        (clk),
        .RESET_N    (rst_a_n),
        .IN         (in_a),
        .freq_bcd   (a_bcd),
        .freq_valid (a_valid),
        .overflow   (a_ovf),
        .cathode    (a_cat),
        .anode      (a_an),
        .DP         (a_dp)
    );

    freq_meter_bcd #(
        .GATE_CYCLES    (1000),
        .DIGITS         (2),
        .REFRESH_CYCLES (8)
    ) dut_b (
        .CLK        (clk),
        .RESET_N    (rst_b_n),
        .IN         (in_b),
        .freq_bcd   (b_bcd),
        .freq_valid (b_valid),
        .overflow   (b_ovf),
        .cathode    (b_cat),
        .anode      (b_an),
        .DP         (b_dp)
    );

    // Cycle counter: number of rising edges so far
    always @(posedge clk) cyc++;

    // Period-10 square wave starting low, restarted when enabled
    initial begin
        sq_in = 1'b0;
        sq_ph = 0;
        forever begin
            @(posedge clk);
            #2;
            if (!sq_en) begin
                sq_ph = 0;
                sq_in = 1'b0;
            end else begin
                sq_in = (sq_ph >= 5);
                sq_ph = (sq_ph + 1) % 10;
            end
        end
    end

    // Period-4 free-running input for the 2-digit instance
    initial begin
        b_ph = 2'd0;
        in_b = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            b_ph = b_ph + 2'd1;
            in_b = b_ph[1];
        end
    end

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    task automatic wait_valid(input bit sel_b, output int t);
        int n;
        n = 0;
        t = -1;
        while (n < 1500 && t < 0) begin
            @(negedge clk);
            n++;
            if (sel_b ? b_valid : a_valid) t = cyc;
        end
        if (t < 0) check(sel_b ? "b_timeout" : "a_timeout", 0, 1);
    endtask

    logic [3:0] exp_an  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [6:0] exp_cat [4] = '{G2, G4, BLK, BLK};

    initial begin
        int         t0;
        int         tv;
        int         tp;
        bit         found;
        logic [3:0] prev;

        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        man_in  = 1'b0;
        sq_en   = 1'b0;

        // Reset with IN toggling
        repeat (3) @(negedge clk);
        man_in = 1'b1;
        repeat (2) @(negedge clk);
        man_in = 1'b0;
        repeat (2) @(negedge clk);
        man_in = 1'b1;
        @(negedge clk);
        check("rst_bcd", a_bcd, 0);
        check("rst_valid", a_valid, 0);
        check("rst_ovf", a_ovf, 0);
        check("rst_anode", a_an, 4'hF);
        check("rst_cathode", a_cat, BLK);
        check("rst_dp", a_dp, 1);
        check("rst_b_anode", b_an, 2'b11);
        check("rst_b_dp", b_dp, 1);

        // Constant high from release
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        t0 = cyc;
        @(negedge clk);
        check("first_anode", a_an, 4'hE);
        check("first_cathode", a_cat, G0);
        check("first_valid", a_valid, 0);
        wait_valid(1'b0, tv);
        check("hi_latency", tv - t0, 1000);
        check("hi_w1_bcd", a_bcd, 16'h0001);
        check("hi_w1_ovf", a_ovf, 0);
        tp = tv;
        wait_valid(1'b0, tv);
        check("hi_period", tv - tp, 1000);
        check("hi_w2_bcd", a_bcd, 16'h0000);

        // Square wave, period 10
        sq_en = 1'b1;
        wait_valid(1'b0, tv);
        for (int w = 0; w < 2; w++) begin
            tp = tv;
            wait_valid(1'b0, tv);
            check("sq_period", tv - tp, 1000);
            check("sq_bcd", a_bcd, 16'h0100);
            check("sq_ovf", a_ovf, 0);
        end

        // 42 pulses in one window, then display scan
        sq_en  = 1'b0;
        man_in = 1'b0;
        wait_valid(1'b0, tv);
        repeat (42) begin
            man_in = 1'b1;
            repeat (5) @(negedge clk);
            man_in = 1'b0;
            repeat (5) @(negedge clk);
        end
        wait_valid(1'b0, tv);
        check("d42_bcd", a_bcd, 16'h0042);
        found = 1'b0;
        prev  = a_an;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (a_an == 4'hE && prev != 4'hE) found = 1'b1;
            else prev = a_an;
        end
        check("scan_align", found, 1);
        for (int r = 0; r < 2; r++) begin
            for (int d = 0; d < 4; d++) begin
                check("scan_an_first", a_an, exp_an[d]);
                check("scan_cat_first", a_cat, exp_cat[d]);
                repeat (7) @(negedge clk);
                check("scan_an_last", a_an, exp_an[d]);
                @(negedge clk);
            end
        end

        // Mid-window reset
        sq_en = 1'b1;
        wait_valid(1'b0, tv);
        repeat (500) @(negedge clk);
        rst_a_n = 1'b0;
        sq_en   = 1'b0;
        #1;
        check("mid_rst_bcd", a_bcd, 0);
        check("mid_rst_valid", a_valid, 0);
        check("mid_rst_anode", a_an, 4'hF);
        check("mid_rst_cathode", a_cat, BLK);
        repeat (3) @(negedge clk);
        rst_a_n = 1'b1;
        sq_en   = 1'b1;
        t0 = cyc;
        wait_valid(1'b0, tv);
        check("mid_latency", tv - t0, 1000);
        check("mid_bcd", a_bcd, 16'h0100);
        check("mid_ovf", a_ovf, 0);

        // Two-digit overflow
        wait_valid(1'b1, tv);
        check("ovf_bcd", b_bcd, 8'h99);
        check("ovf_flag", b_ovf, 1);
        for (int k = 0; k < 4; k++) begin
            repeat (8) @(negedge clk);
            check("ovf_anode_onehot",
                  (b_an == 2'b10 || b_an == 2'b01), 1);
            check("ovf_dash", b_cat, DASH);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
